// File: rtl/biu_pkg.sv
// Shared types and constants for the bus interface unit.
package biu_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    MEM    = 3'd2,
    WB     = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [1:0] SEL_MOV = 2'b00;
  localparam logic [1:0] SEL_LST = 2'b01;

  localparam int IR_MOVI    = 19;
  localparam int IR_ST      = 18;
  localparam int IR_RD_LSB  = 12;
  localparam int IR_RS_LSB  = 8;
  localparam int IR_IMM_LSB = 0;

  typedef struct packed {
    logic       movi;
    logic       st;
    logic [3:0] rd;
    logic [3:0] rs;
    logic [7:0] imm;
  } cmd_t;

endpackage

// File: rtl/biu_timeout_ctr.sv
// Wait counter for the MEM state; tc_o flags the last allowed cycle.
module biu_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == W'(TIMEOUT - 1));
endmodule

// File: rtl/biu_unit.sv
// Bus interface unit: executes mov and load/store commands dispatched by the decoder.
module biu_unit
  import biu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_biu,
  input  logic [1:0]        sel_biu,
  input  logic [31:0]       ir,
  output logic              ready_bus,
  output logic              err,
  output logic [3:0]        rf_raddr_a,
  input  logic [DATA_W-1:0] rf_rdata_a,
  output logic [3:0]        rf_raddr_b,
  input  logic [DATA_W-1:0] rf_rdata_b,
  output logic              rf_we,
  output logic [3:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  state_t            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic [1:0]        sel_q, sel_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              mwe_q, mwe_d;
  logic [DATA_W-1:0] mwdata_q, mwdata_d;
  logic              tc;
  logic              cs_on;

  // Only a solid 1 dispatches; X/Z on the select line are treated as idle.
  assign cs_on = (cs_biu === 1'b1);

  biu_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (state_q != MEM),
    .en_i  (state_q == MEM),
    .tc_o  (tc)
  );

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    sel_d    = sel_q;
    err_d    = err_q;
    wdata_d  = wdata_q;
    addr_d   = addr_q;
    mwe_d    = mwe_q;
    mwdata_d = mwdata_q;
    unique case (state_q)
      IDLE: begin
        if (cs_on) begin
          cmd_d.movi = ir[IR_MOVI];
          cmd_d.st   = ir[IR_ST];
          cmd_d.rd   = ir[IR_RD_LSB +: 4];
          cmd_d.rs   = ir[IR_RS_LSB +: 4];
          cmd_d.imm  = ir[IR_IMM_LSB +: 8];
          sel_d      = sel_biu;
          err_d      = 1'b0;
          state_d    = DECODE;
        end
      end
      DECODE: begin
        if (sel_q == SEL_MOV) begin
          wdata_d = cmd_q.movi ? DATA_W'(cmd_q.imm) : rf_rdata_a;
          state_d = WB;
        end else if (sel_q == SEL_LST) begin
          addr_d   = rf_rdata_a[ADDR_W-1:0] + ADDR_W'(cmd_q.imm);
          mwe_d    = cmd_q.st;
          mwdata_d = rf_rdata_b;
          state_d  = MEM;
        end else begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      MEM: begin
        if (mem_ack) begin
          if (mwe_q) begin
            state_d = DONE;
          end else begin
            wdata_d = mem_rdata;
            state_d = WB;
          end
        end else if (tc) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      WB:   state_d = DONE;
      DONE: if (!cs_on) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      sel_q    <= '0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      addr_q   <= '0;
      mwe_q    <= 1'b0;
      mwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      sel_q    <= sel_d;
      err_q    <= err_d;
      wdata_q  <= wdata_d;
      addr_q   <= addr_d;
      mwe_q    <= mwe_d;
      mwdata_q <= mwdata_d;
    end
  end

  assign ready_bus  = (state_q == DONE);
  assign err        = err_q;
  assign rf_raddr_a = cmd_q.rs;
  assign rf_raddr_b = cmd_q.rd;
  assign rf_we      = (state_q == WB);
  assign rf_waddr   = cmd_q.rd;
  assign rf_wdata   = wdata_q;
  assign mem_req    = (state_q == MEM);
  assign mem_we     = mwe_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = mwdata_q;

  logic unused_bits;
  assign unused_bits = ^{ir[31:20], ir[17:16], rf_rdata_a[DATA_W-1:ADDR_W]};

endmodule

// File: tb/tb_biu_unit.sv
// Randomized and directed bench for biu_unit against a transaction-level model.
module tb_biu_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs_biu;
  logic [1:0]  sel_biu;
  logic [31:0] ir;
  logic        ready_bus, err;
  logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [31:0] rf_rdata_a, rf_rdata_b, rf_wdata;
  logic        rf_we;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;

  logic [31:0] rf [16];
  assign rf_rdata_a = rf[rf_raddr_a];
  assign rf_rdata_b = rf[rf_raddr_b];

  always #5 clk = ~clk;

  biu_unit #(.DATA_W(32), .ADDR_W(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cs_biu(cs_biu), .sel_biu(sel_biu), .ir(ir),
    .ready_bus(ready_bus), .err(err),
    .rf_raddr_a(rf_raddr_a), .rf_rdata_a(rf_rdata_a),
    .rf_raddr_b(rf_raddr_b), .rf_rdata_b(rf_rdata_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  int checks = 0;
  int errors = 0;

  // Observations of one command
  int          o_rdy_edge, o_rdy_len, o_we_cnt, o_we_edge, o_req_cnt;
  logic [3:0]  o_waddr;
  logic [31:0] o_wdata, o_mwdata;
  logic [15:0] o_addr;
  logic        o_mwe, o_err, o_err_idle, o_unstable;

  typedef struct {
    int          rdy_edge;
    int          we_cnt;
    int          req_cnt;
    logic [31:0] wdata;
    logic [15:0] addr;
    logic        mwe;
    logic [31:0] mwdata;
    logic        err;
  } exp_t;

  // Outcome of a command from the instruction-level rules and the bench register file.
  function automatic exp_t model(input logic [1:0] s, input logic [31:0] w, input int wt,
                                 input logic [31:0] rdv);
    exp_t e;
    logic [3:0] rs, rd;
    bit tmo;
    rs = w[11:8];
    rd = w[15:12];
    tmo = (s == 2'b01) && (wt < 0 || wt >= TO);
    e.addr   = 16'((int'(rf[rs][15:0]) + int'(w[7:0])) % 65536);
    e.mwe    = w[18];
    e.mwdata = rf[rd];
    e.err    = s[1] || tmo;
    e.wdata  = 32'h0;
    e.req_cnt = 0;
    e.we_cnt  = 0;
    if (s[1]) e.rdy_edge = 2;
    else if (s == 2'b00) begin
      e.rdy_edge = 3; e.we_cnt = 1;
      e.wdata = w[19] ? {24'h0, w[7:0]} : rf[rs];
    end else if (tmo) begin
      e.rdy_edge = 2 + TO; e.req_cnt = TO;
    end else begin
      e.req_cnt = wt + 1;
      if (w[18]) e.rdy_edge = 3 + wt;
      else begin e.rdy_edge = 4 + wt; e.we_cnt = 1; e.wdata = rdv; end
    end
    return e;
  endfunction

  // Drive one command, act as memory responder, and record what the DUT did.
  task automatic run_cmd(input logic [1:0] s, input logic [31:0] w, input int wt,
                         input logic [31:0] rdv, input bit early, input int hold);
    int edge_n, reqc, rdyc;
    bit done;
    o_rdy_edge = -1; o_we_cnt = 0; o_we_edge = -1; o_unstable = 0;
    o_err = 1'bx; o_err_idle = 1'bx;
    @(negedge clk);
    sel_biu = s; ir = w; cs_biu = 1'b1; mem_ack = 1'b0;
    edge_n = 0; reqc = 0; rdyc = 0; done = 0;
    while (!done && edge_n < 60) begin
      @(posedge clk); edge_n++;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = $urandom;
      if (early && edge_n == 1) cs_biu = 1'b0;
      if (rf_we) begin
        o_we_cnt++; o_we_edge = edge_n; o_waddr = rf_waddr; o_wdata = rf_wdata;
      end
      if (mem_req) begin
        if (reqc == 0) begin o_addr = mem_addr; o_mwe = mem_we; o_mwdata = mem_wdata; end
        else if ({mem_addr, mem_we, mem_wdata} !== {o_addr, o_mwe, o_mwdata}) o_unstable = 1;
        if (wt >= 0 && reqc == wt) begin mem_ack = 1'b1; mem_rdata = rdv; end
        reqc++;
      end
      if (ready_bus) begin
        if (o_rdy_edge < 0) begin o_rdy_edge = edge_n; o_err = err; end
        rdyc++;
        if (rdyc == hold) cs_biu = 1'b0;
      end else if (o_rdy_edge >= 0) begin
        done = 1; o_err_idle = err;
      end
    end
    o_req_cnt = reqc; o_rdy_len = rdyc;
    cs_biu = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cs_biu = 1'b0; sel_biu = 2'b00; ir = '0; mem_ack = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 16; i++) rf[i] = $urandom;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ready_bus, err, rf_we, mem_req, mem_we, mem_addr, mem_wdata, rf_wdata, rf_waddr}
        !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b err=%b we=%b req=%b mwe=%b addr=%h, all required 0",
               ready_bus, err, rf_we, mem_req, mem_we, mem_addr);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_mov_imm();
    run_cmd(2'b00, 32'h0008_305A, 0, 0, 0, 3);
    checks++; if (o_we_edge !== 2 || o_we_cnt !== 1) begin errors++;
      $display("FAIL mov_we: edge %0d cnt %0d, required edge 2 cnt 1", o_we_edge, o_we_cnt); end
    checks++; if (o_waddr !== 4'd3 || o_wdata !== 32'h5A) begin errors++;
      $display("FAIL mov_wb: addr %0d data %h, required 3 0000005a", o_waddr, o_wdata); end
    checks++; if (o_rdy_edge !== 3 || o_rdy_len !== 3) begin errors++;
      $display("FAIL mov_ready: edge %0d len %0d, required 3 3", o_rdy_edge, o_rdy_len); end
    checks++; if (o_err !== 1'b0) begin errors++;
      $display("FAIL mov_err: %b, required 0", o_err); end
  endtask

  task automatic test_load();
    rf[1] = 32'h0000_0FF0; rf[2] = 32'h1111_1111;
    run_cmd(2'b01, 32'h0000_2110, 2, 32'hDEAD_BEEF, 0, 1);
    checks++; if (o_addr !== 16'h1000 || o_mwe !== 1'b0 || o_unstable) begin errors++;
      $display("FAIL load_req: addr %h we %b unstable %b, required 1000 0 0",
               o_addr, o_mwe, o_unstable); end
    checks++; if (o_we_cnt !== 1 || o_waddr !== 4'd2 || o_wdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL load_wb: cnt %0d addr %0d data %h, required 1 2 deadbeef",
               o_we_cnt, o_waddr, o_wdata); end
    checks++; if (o_rdy_edge !== 6 || o_req_cnt !== 3) begin errors++;
      $display("FAIL load_timing: ready edge %0d req cycles %0d, required 6 3",
               o_rdy_edge, o_req_cnt); end
  endtask

  task automatic test_store_wrap();
    rf[4] = 32'h0000_FFFF; rf[5] = 32'hCAFE_F00D;
    run_cmd(2'b01, 32'h0004_5402, 0, 0, 1, 1);
    checks++; if (o_addr !== 16'h0001 || o_mwe !== 1'b1 || o_mwdata !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL store_req: addr %h we %b data %h, required 0001 1 cafef00d",
               o_addr, o_mwe, o_mwdata); end
    checks++; if (o_we_cnt !== 0 || o_rdy_edge !== 3 || o_rdy_len !== 1) begin errors++;
      $display("FAIL store_done: rf_we %0d ready edge %0d len %0d, required 0 3 1",
               o_we_cnt, o_rdy_edge, o_rdy_len); end
  endtask

  task automatic test_timeout();
    run_cmd(2'b01, 32'h0000_6700, -1, 0, 0, 2);
    checks++; if (o_req_cnt !== TO || o_we_cnt !== 0) begin errors++;
      $display("FAIL timeout_req: req cycles %0d rf_we %0d, required %0d 0",
               o_req_cnt, o_we_cnt, TO); end
    checks++; if (o_err !== 1'b1 || o_err_idle !== 1'b1 || o_rdy_edge !== 2 + TO) begin
      errors++;
      $display("FAIL timeout_err: err %b idle err %b ready edge %0d, required 1 1 %0d",
               o_err, o_err_idle, o_rdy_edge, 2 + TO); end
    run_cmd(2'b00, 32'h0008_1011, 0, 0, 0, 1);
    checks++; if (o_err !== 1'b0 || o_wdata !== 32'h11) begin errors++;
      $display("FAIL err_clear: err %b data %h, required 0 00000011", o_err, o_wdata); end
  endtask

  task automatic test_reserved();
    run_cmd(2'b10, 32'h0004_7700, 0, 0, 0, 1);
    checks++; if (o_req_cnt !== 0 || o_we_cnt !== 0 || o_err !== 1'b1 || o_rdy_edge !== 2)
    begin errors++;
      $display("FAIL reserved: req %0d we %0d err %b ready edge %0d, required 0 0 1 2",
               o_req_cnt, o_we_cnt, o_err, o_rdy_edge); end
  endtask

  task automatic test_reset_mid();
    int n, bad;
    @(negedge clk);
    sel_biu = 2'b01; ir = 32'h0000_8300; cs_biu = 1'b1; mem_ack = 1'b0;
    n = 0;
    while (!mem_req && n < 10) begin @(posedge clk); @(negedge clk); cs_biu = 1'b0; n++; end
    checks++; if (mem_req !== 1'b1) begin errors++;
      $display("FAIL midrst_req: mem_req %b, required 1", mem_req); end
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if ({mem_req, ready_bus, err, rf_we} !== 4'b0) begin errors++;
      $display("FAIL midrst_out: req %b rdy %b err %b we %b, required 0", mem_req, ready_bus,
               err, rf_we); end
    rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    bad = 0;
    repeat (6) begin
      @(posedge clk); @(negedge clk); mem_ack = 1'b0;
      if (rf_we || mem_req || ready_bus) bad++;
    end
    checks++; if (bad !== 0) begin errors++;
      $display("FAIL midrst_late_ack: %0d active cycles, required 0", bad); end
  endtask

  task automatic test_random();
    exp_t e;
    logic [1:0] s;
    logic [31:0] w, rdv;
    int wt, hold;
    bit early;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 16; i++) rf[i] = $urandom;
      case ($urandom_range(0, 7))
        0:       s = 2'(2 + $urandom_range(0, 1));
        1, 2:    s = 2'b00;
        default: s = 2'b01;
      endcase
      w = $urandom; rdv = $urandom;
      wt = $urandom_range(0, 5) == 0 ? -1 : $urandom_range(0, TO);
      early = $urandom_range(0, 1) == 1;
      hold = early ? 1 : $urandom_range(1, 3);
      e = model(s, w, wt, rdv);
      run_cmd(s, w, wt, rdv, early, hold);
      checks++; if (o_rdy_edge !== e.rdy_edge || o_rdy_len !== hold) begin errors++;
        $display("FAIL rnd%0d_ready: edge %0d len %0d, required %0d %0d", it, o_rdy_edge,
                 o_rdy_len, e.rdy_edge, hold); end
      checks++; if (o_err !== e.err || o_err_idle !== e.err) begin errors++;
        $display("FAIL rnd%0d_err: %b/%b, required %b", it, o_err, o_err_idle, e.err); end
      checks++; if (o_we_cnt !== e.we_cnt || o_req_cnt !== e.req_cnt) begin errors++;
        $display("FAIL rnd%0d_counts: we %0d req %0d, required %0d %0d", it, o_we_cnt,
                 o_req_cnt, e.we_cnt, e.req_cnt); end
      if (e.we_cnt == 1) begin
        checks++; if (o_waddr !== w[15:12] || o_wdata !== e.wdata) begin errors++;
          $display("FAIL rnd%0d_wb: addr %0d data %h, required %0d %h", it, o_waddr, o_wdata,
                   w[15:12], e.wdata); end
      end
      if (e.req_cnt > 0) begin
        checks++;
        if (o_addr !== e.addr || o_mwe !== e.mwe || o_unstable ||
            (e.mwe && o_mwdata !== e.mwdata)) begin errors++;
          $display("FAIL rnd%0d_mem: addr %h we %b data %h unstable %b, required %h %b %h",
                   it, o_addr, o_mwe, o_mwdata, o_unstable, e.addr, e.mwe, e.mwdata); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_mov_imm();
    test_load();
    test_store_wrap();
    test_timeout();
    test_reserved();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/biu_unit.md
Name: biu_unit

Overview:
- Bus interface unit: the responder end of the dispatch handshake driven by the instruction decoder (cs_biu / sel_biu / ready_bus).
- Executes mov and load/store instructions: reads the register file, issues memory requests, writes results back.
- Raises ready_bus on completion and holds it until the decoder releases cs_biu.

Parameters:
- DATA_W, 32, register and memory data width
- ADDR_W, 16, memory address width; address arithmetic wraps modulo 2^ADDR_W
- TIMEOUT, 16, maximum cycles mem_req is held waiting for mem_ack (must be >= 1)

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- cs_biu  in  1  dispatch select; only logic 1 counts as asserted (0, Z and X are inactive)
- sel_biu  in  2  operation: 00 mov, 01 load/store, 1x reserved
- ir  in  32  instruction word; fields used: [19] mov-immediate, [18] store, [15:12] rd, [11:8] rs, [7:0] imm8/offset
- ready_bus  out  1  operation complete
- err  out  1  last operation failed (timeout or reserved sel)
- rf_raddr_a  out  4  register-file read port A address (= rs)
- rf_rdata_a  in  DATA_W  port A data, combinational read
- rf_raddr_b  out  4  read port B address (= rd, store data)
- rf_rdata_b  in  DATA_W  port B data, combinational read
- rf_we  out  1  register-file write enable
- rf_waddr  out  4  write address
- rf_wdata  out  DATA_W  write data
- mem_req  out  1  memory request, level, held until acknowledged
- mem_we  out  1  1 = store, 0 = load; valid while mem_req is high
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  store data
- mem_rdata  in  DATA_W  load data, valid in the cycle mem_ack = 1
- mem_ack  in  1  single-cycle acknowledge

Behaviour:
- Reset (rst_n = 0 at a clock edge): state IDLE; every output 0, including ready_bus and err; wait counter 0.
- Reset mid-operation aborts the operation immediately. No rf_we or mem_req is asserted afterwards.
- States: IDLE, DECODE, MEM, WB, DONE.
- IDLE: if cs_biu === 1, latch ir and sel_biu, clear err, go to DECODE. ready_bus = 0.
- DECODE: rf_raddr_a = rs, rf_raddr_b = rd.
  - sel 00: rf_wdata = (ir[19] ? zero-extended imm8 : rf_rdata_a); go to WB.
  - sel 01: mem_addr = (rf_rdata_a[ADDR_W-1:0] + imm8) mod 2^ADDR_W; mem_we = ir[18]; mem_wdata = rf_rdata_b; all registered; go to MEM.
  - sel 1x: err = 1; go to DONE.
- MEM: mem_req = 1; address, data and we are held stable.
  - mem_ack = 1: drop mem_req next cycle. A load captures mem_rdata into rf_wdata and goes to WB; a store goes to DONE.
  - Otherwise the counter increments. If the counter reaches TIMEOUT-1 without ack: err = 1, drop mem_req, go to DONE, no writeback.
  - If ack and the final timeout cycle coincide, ack wins.
- WB: rf_we = 1 for exactly one cycle, rf_waddr = rd; go to DONE.
- DONE: ready_bus = 1. Stay while cs_biu === 1. Leave to IDLE the first cycle cs_biu is not 1, with ready_bus = 0 from the next cycle. ready_bus is high for at least one cycle.
- cs_biu deasserting before DONE is ignored; the operation completes.
- A new cs_biu is only accepted from IDLE, so back-to-back commands need one idle cycle.
- mem_ack outside MEM is ignored.
- Latency, counted from the edge that samples cs_biu in IDLE to ready_bus high:
  - mov: 3 edges
  - store: 3 + wait edges
  - load: 4 + wait edges
  - where wait = number of cycles mem_req is high without ack.
- err holds its value through DONE and IDLE; it is cleared when the next command starts.

Decomposition:
- Shared package biu_pkg:
  - state encoding constants: IDLE, DECODE, MEM, WB, DONE
  - sel_biu codes: SEL_MOV = 2'b00, SEL_LST = 2'b01
  - ir field bit positions
- One natural sub-module, biu_timeout_ctr: a load/enable/terminal-count counter of width clog2(TIMEOUT) used in MEM.
- Everything else stays in biu_unit.

Test Plan:
- mov immediate: ir[19] = 1, rd = 3, imm8 = 0x5A, sel = 00, cs held high -> rf_we pulse with waddr 3, wdata 0x5A at edge 2; ready_bus high from edge 3 until cs drops; err = 0.
- load: rf[rs] = 0x0FF0, offset 0x10, ack after 2 wait cycles with rdata 0xDEADBEEF -> mem_addr 0x1000, mem_we 0, rf write of 0xDEADBEEF to rd; ready_bus at edge 6.
- store with address wrap: rf[rs] = 0xFFFF, offset 0x02, ack immediately -> mem_addr 0x0001, mem_we 1, mem_wdata = rf[rd], no rf_we, ready_bus at edge 3.
- timeout: TIMEOUT = 4, never ack -> mem_req high exactly 4 cycles then low, err = 1, ready_bus = 1, no rf_we; next mov clears err.
- reserved sel_biu = 2'b10 -> no mem_req, no rf_we, err = 1, ready_bus high at edge 2.
- rst_n low during MEM with mem_req high -> next edge: mem_req 0, ready_bus 0, err 0, state IDLE; a late mem_ack causes no rf_we.
